// File: rtl/softmax_arbiter_if.sv
// softmax_arbiter_if: requester-side and engine-side signals of
// the shared softmax engine arbiter.
interface softmax_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int VEC_SIZE   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]                               req;
    logic [NUM_REQ-1:0][VEC_SIZE-1:0][DATA_WIDTH-1:0] req_vec;
    logic [NUM_REQ-1:0]                               grant;
    logic                                             busy;
    logic                                             sm_enable;
    logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]              sm_vec_in;
    logic                                             sm_data_valid;
    logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]              sm_vec_out;
    logic                                             resp_done;
    logic                                             resp_err;
    logic [ID_W-1:0]                                  resp_id;
    logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]              resp_vec;

    modport slave (
        input  req, req_vec, sm_data_valid, sm_vec_out,
        output grant, busy, sm_enable, sm_vec_in,
        output resp_done, resp_err, resp_id, resp_vec
    );

    modport master (
        output req, req_vec, sm_data_valid, sm_vec_out,
        input  grant, busy, sm_enable, sm_vec_in,
        input  resp_done, resp_err, resp_id, resp_vec
    );
endinterface

// File: rtl/softmax_arbiter.sv
// softmax_arbiter: round-robin sharing of one softmax engine among
// NUM_REQ requesters, with a RUN timeout and an enable-low re-arm gap.
module softmax_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int VEC_SIZE   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PNT  = 8,
    parameter int TIMEOUT    = 31,
    parameter int GAP_CYCLES = 1
) (
    input logic              clk,
    input logic              rst_n,
    softmax_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, GAP} state_t;
    typedef logic [VEC_SIZE-1:0][DATA_WIDTH-1:0] vec_t;

    if (NUM_REQ < 2 || GAP_CYCLES < 1 || TIMEOUT < 1 ||
        FIXED_PNT >= DATA_WIDTH) begin : g_param_chk
        $error("softmax_arbiter: illegal parameter set");
    end

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [GW-1:0]      gcnt_q, gcnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               en_q, en_d;
    vec_t               vin_q, vin_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [ID_W-1:0]    rid_q, rid_d;
    vec_t               rvec_q, rvec_d;

    logic               pick_ok;
    logic [ID_W-1:0]    pick_id;
    logic [TW-1:0]      tinc;

    // First requester at or after rr_q, wrapping around.
    always_comb begin
        int unsigned     j;
        logic [ID_W-1:0] idx;
        pick_ok = 1'b0;
        pick_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(rr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            idx = ID_W'(j);
            if (!pick_ok && bus.req[idx]) begin
                pick_ok = 1'b1;
                pick_id = idx;
            end
        end
    end

    assign tinc = (tcnt_q == TW'(TIMEOUT)) ? tcnt_q : tcnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        grant_d = '0;
        busy_d  = busy_q;
        en_d    = en_q;
        vin_d   = vin_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rid_d   = rid_q;
        rvec_d  = rvec_q;
        unique case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    state_d = RUN;
                    id_d    = pick_id;
                    grant_d = NUM_REQ'(1) << pick_id;
                    vin_d   = bus.req_vec[pick_id];
                    busy_d  = 1'b1;
                    en_d    = 1'b1;
                    tcnt_d  = '0;
                    rr_d    = (pick_id == ID_W'(NUM_REQ - 1)) ?
                              '0 : pick_id + 1'b1;
                end
            end
            RUN: begin
                tcnt_d = tinc;
                if (bus.sm_data_valid) begin
                    state_d = DRAIN;
                    en_d    = 1'b0;
                end else if (tinc == TW'(TIMEOUT)) begin
                    state_d = GAP;
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    rid_d   = id_q;
                    gcnt_d  = '0;
                end
            end
            DRAIN: begin
                // Engine result is valid the cycle after its valid pulse.
                rvec_d  = bus.sm_vec_out;
                done_d  = 1'b1;
                rid_d   = id_q;
                state_d = GAP;
                gcnt_d  = '0;
            end
            GAP: begin
                if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            vin_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rid_q   <= '0;
            rvec_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            vin_q   <= vin_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rid_q   <= rid_d;
            rvec_q  <= rvec_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.sm_enable = en_q;
    assign bus.sm_vec_in = vin_q;
    assign bus.resp_done = done_q;
    assign bus.resp_err  = err_q;
    assign bus.resp_id   = rid_q;
    assign bus.resp_vec  = rvec_q;
endmodule

// File: tb/tb_softmax_arbiter.sv
// tb_softmax_arbiter: directed and random stimulus against a
// round-robin reference model and a behavioural engine model.
module tb_softmax_arbiter;
    localparam int NR  = 4;
    localparam int VS  = 4;
    localparam int DW  = 16;
    localparam int TO  = 31;
    localparam int GAP = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   rr_m   = 0;

    softmax_arbiter_if #(.NUM_REQ(NR), .VEC_SIZE(VS),
                         .DATA_WIDTH(DW)) bus ();

    softmax_arbiter #(
        .NUM_REQ(NR), .VEC_SIZE(VS), .DATA_WIDTH(DW),
        .FIXED_PNT(8), .TIMEOUT(TO), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] eng_f(input logic [63:0] v);
        return {v[47:0], v[63:48]} ^ 64'h5a5a_0f0f_a5a5_f0f0;
    endfunction

    function automatic int pick(input int rr, input logic [NR-1:0] m);
        for (int i = 0; i < NR; i++) begin
            if (m[(rr + i) % NR]) return (rr + i) % NR;
        end
        return -1;
    endfunction

    // Engine model: valid after eng_lat enabled cycles (0 = hang),
    // result one cycle later, re-armed only by enable going low.
    int eng_lat   = 4;
    int stray_cyc = -10;
    int cyc       = 0;
    int en_cnt    = 0;
    bit armed     = 1'b1;
    bit pend      = 1'b0;

    always @(posedge clk) begin
        #1;
        bus.sm_data_valid = 1'b0;
        if (pend) bus.sm_vec_out = eng_f(bus.sm_vec_in);
        else bus.sm_vec_out = {$urandom, $urandom};
        pend = 1'b0;
        if (bus.sm_enable === 1'b1) en_cnt++;
        else begin
            en_cnt = 0;
            armed  = 1'b1;
        end
        if (bus.sm_enable === 1'b1 && armed && eng_lat != 0 &&
            en_cnt == eng_lat) begin
            bus.sm_data_valid = 1'b1;
            armed = 1'b0;
            pend  = 1'b1;
        end
        if (stray_cyc == cyc + 1) bus.sm_data_valid = 1'b1;
    end

    int en_run = 0, low_run = 0, last_en_len = 0, last_low = 0;
    int valid_cyc = -100, done_cyc = -100, n_done = 0, n_err = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus.sm_enable === 1'b1) begin
            if (low_run > 0) begin
                last_low = low_run;
                low_run  = 0;
            end
            en_run++;
        end else begin
            if (en_run > 0) begin
                last_en_len = en_run;
                en_run      = 0;
            end
            low_run++;
        end
        if (bus.sm_data_valid === 1'b1) valid_cyc = cyc;
        if (bus.resp_done === 1'b1) begin
            done_cyc = cyc;
            n_done++;
        end
        if (bus.resp_err === 1'b1) n_err++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int i = 0; i < 100 && g < 0; i++) begin
            step();
            for (int k = 0; k < NR; k++) if (bus.grant[k] === 1'b1) g = k;
        end
        if (g < 0) begin
            checks++;
            errors++;
            $error("FAIL grant_wait got=none exp=grant");
        end
    endtask

    task automatic wait_resp(output logic d, output logic e);
        d = 1'b0;
        e = 1'b0;
        for (int i = 0; i < 80 && !(d || e); i++) begin
            step();
            d = bus.resp_done;
            e = bus.resp_err;
        end
        if (!(d || e)) begin
            checks++;
            errors++;
            $error("FAIL resp_wait got=none exp=response");
        end
    endtask

    // mode 0: drop req at response, 1: hold req,
    // 2: drop req mid-RUN, 3: stray valid inside GAP
    task automatic serve(input string tag, input bit exp_err,
                         input int mode);
        int            g, exp_id;
        logic          d, e;
        logic [63:0]   v;
        logic [NR-1:0] oh;
        exp_id = pick(rr_m, bus.req);
        wait_grant(g);
        oh = '0;
        if (exp_id >= 0) oh[exp_id] = 1'b1;
        chk({tag, "_grant"}, bus.grant, oh);
        if (g < 0 || exp_id < 0) return;
        rr_m = (exp_id + 1) % NR;
        v = bus.req_vec[exp_id];
        chk({tag, "_vin"}, bus.sm_vec_in, v);
        if (mode == 2) begin
            step();
            step();
            bus.req[exp_id] = 1'b0;
        end
        if (mode == 3) begin
            for (int i = 0; i < 20 && bus.sm_data_valid !== 1'b1; i++)
                step();
            stray_cyc = cyc + 2;
        end
        wait_resp(d, e);
        chk({tag, "_kind"}, {d, e}, exp_err ? 2'b01 : 2'b10);
        chk({tag, "_id"}, bus.resp_id, exp_id);
        if (!exp_err) chk({tag, "_vec"}, bus.resp_vec, eng_f(v));
        if (mode == 0 || mode == 3) bus.req[exp_id] = 1'b0;
    endtask

    initial begin
        int            g, ex, nd, ne, tgt, ops, cur;
        logic [NR-1:0] oh;
        logic [63:0]   cur_v;
        bit            cur_to;
        bus.req     = '0;
        bus.req_vec = '0;
        rst_n       = 1'b0;
        step();
        step();
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_en", bus.sm_enable, 0);
        chk("rst_done", bus.resp_done, 0);
        chk("rst_err", bus.resp_err, 0);
        chk("rst_id", bus.resp_id, 0);
        chk("rst_rvec", bus.resp_vec, 0);
        chk("rst_vin", bus.sm_vec_in, 0);
        rst_n = 1'b1;
        rr_m  = 0;

        bus.req_vec[2] = {16'd4, 16'd3, 16'd2, 16'd1};
        eng_lat = 4;
        bus.req = 4'b0100;
        serve("single", 1'b0, 0);
        chk("single_en_len", last_en_len, 4);
        chk("single_lat", done_cyc - valid_cyc, 2);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rr_m  = 0;
        eng_lat = 3;
        for (int i = 0; i < NR; i++) bus.req_vec[i] = {$urandom, $urandom};
        bus.req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            serve("rr", 1'b0, 1);
            if (n > 0) chk("rr_gap", last_low >= GAP, 1);
        end
        bus.req = '0;
        step();
        step();

        eng_lat = 0;
        bus.req_vec[1] = {$urandom, $urandom};
        bus.req = 4'b0010;
        serve("tmo", 1'b1, 0);
        chk("tmo_en_len", last_en_len, TO);
        ne = n_err;
        nd = n_done;
        step();
        step();
        step();
        chk("tmo_once", n_err, ne);
        chk("tmo_nodone", n_done, nd);
        eng_lat = 3;
        bus.req_vec[3] = {$urandom, $urandom};
        bus.req = 4'b1000;
        serve("after_tmo", 1'b0, 0);

        eng_lat = 8;
        bus.req = 4'b0010;
        ex = pick(rr_m, bus.req);
        wait_grant(g);
        chk("rrun_grant", g, ex);
        step();
        chk("rrun_en2", bus.sm_enable, 1);
        nd = n_done;
        ne = n_err;
        rst_n   = 1'b0;
        bus.req = '0;
        step();
        chk("rrun_en", bus.sm_enable, 0);
        chk("rrun_busy", bus.busy, 0);
        chk("rrun_resp", {bus.resp_done, bus.resp_err}, 0);
        rst_n = 1'b1;
        rr_m  = 0;
        step();
        step();
        step();
        chk("rrun_noresp", n_done + n_err, nd + ne);
        bus.req_vec[3] = {$urandom, $urandom};
        eng_lat = 4;
        bus.req = 4'b1000;
        serve("rrun_next", 1'b0, 0);

        eng_lat = 6;
        bus.req_vec[1] = {$urandom, $urandom};
        bus.req = 4'b0010;
        serve("drop", 1'b0, 2);

        step();
        step();
        nd  = n_done;
        tgt = cyc + 2;
        stray_cyc = tgt;
        for (int i = 0; i < 4; i++) step();
        chk("stray_idle_seen", valid_cyc, tgt);
        chk("stray_idle_done", n_done, nd);
        chk("stray_idle_busy", bus.busy, 0);
        chk("stray_idle_en", bus.sm_enable, 0);
        eng_lat = 3;
        bus.req_vec[2] = {$urandom, $urandom};
        bus.req = 4'b0100;
        serve("stray_gap", 1'b0, 3);
        tgt = stray_cyc;
        nd  = n_done;
        for (int i = 0; i < 5; i++) step();
        chk("stray_gap_seen", valid_cyc, tgt);
        chk("stray_gap_done", n_done, nd);
        chk("stray_gap_busy", bus.busy, 0);
        chk("stray_gap_en", bus.sm_enable, 0);

        bus.req_vec[0] = {$urandom, $urandom};
        bus.req = 4'b0001;
        serve("pair_first", 1'b0, 0);
        bus.req_vec[0] = {$urandom, $urandom};
        bus.req_vec[2] = {$urandom, $urandom};
        bus.req = 4'b0101;
        serve("pair_a", 1'b0, 0);
        serve("pair_b", 1'b0, 0);

        ops    = 0;
        cur    = -1;
        cur_v  = '0;
        cur_to = 1'b0;
        for (int c = 0; c < 4000 && ops < 40; c++) begin
            step();
            if (bus.grant != 0) begin
                ex = pick(rr_m, bus.req);
                oh = '0;
                if (ex >= 0) oh[ex] = 1'b1;
                chk("rnd_grant", bus.grant, oh);
                if (ex >= 0) begin
                    cur    = ex;
                    cur_v  = bus.req_vec[ex];
                    rr_m   = (ex + 1) % NR;
                end
                cur_to  = ($urandom_range(0, 9) == 0);
                eng_lat = cur_to ? 0 : int'($urandom_range(2, 8));
            end
            if (bus.resp_done === 1'b1 || bus.resp_err === 1'b1) begin
                chk("rnd_kind", {bus.resp_done, bus.resp_err},
                    cur_to ? 2'b01 : 2'b10);
                chk("rnd_id", bus.resp_id, cur);
                if (!cur_to) chk("rnd_vec", bus.resp_vec, eng_f(cur_v));
                if (cur >= 0) bus.req[cur] = 1'b0;
                ops++;
            end
            for (int k = 0; k < NR; k++) begin
                if (!bus.req[k] && $urandom_range(0, 3) == 0) begin
                    bus.req_vec[k] = {$urandom, $urandom};
                    bus.req[k]     = 1'b1;
                end
            end
        end
        chk("rnd_ops", ops, 40);
        bus.req = '0;
        for (int i = 0; i < 60 && bus.busy !== 1'b0; i++) step();
        chk("end_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/softmax_arbiter.md
Name: softmax_arbiter

Overview:
- Shares one softmax engine between NUM_REQ requesters using round-robin arbitration.
- Latches the granted requester's vector and holds the engine enable until the engine's data-valid pulse arrives.
- Captures the result, returns it with a one-cycle done pulse tagged with the requester index, then enforces an enable-low gap so the engine's edge-detected valid re-arms.
- A timeout guards against a hung engine.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- VEC_SIZE, 4, elements per vector; must match the engine.
- DATA_WIDTH, 16, element width; signed fixed-point.
- FIXED_PNT, 8, fractional bits; passed through, no arithmetic here.
- TIMEOUT, 31, maximum RUN cycles waiting for sm_data_valid.
- GAP_CYCLES, 1, minimum cycles sm_enable stays low between operations (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  NUM_REQ  per-requester request level; held until that requester's resp_done or resp_err.
- req_vec  in  DATA_WIDTH x VEC_SIZE x NUM_REQ  signed input vector per requester.
- grant  out  NUM_REQ  one-hot, pulses 1 cycle when a requester's vector is latched.
- busy  out  1  high from grant until the end of GAP.
- sm_enable  out  1  engine enable.
- sm_vec_in  out  DATA_WIDTH x VEC_SIZE  latched operand to the engine.
- sm_data_valid  in  1  engine one-cycle valid pulse.
- sm_vec_out  in  DATA_WIDTH x VEC_SIZE  engine result; valid the cycle after sm_data_valid.
- resp_done  out  1  one-cycle pulse, result valid.
- resp_err  out  1  one-cycle pulse, timeout.
- resp_id  out  $clog2(NUM_REQ)  requester index for resp_done or resp_err; held until the next response.
- resp_vec  out  DATA_WIDTH x VEC_SIZE  captured result; held until the next resp_done.

Behaviour:
- Reset (rst_n low at posedge), regardless of state:
  - state = IDLE; all outputs 0, including resp_vec, sm_vec_in and resp_id.
  - rr pointer = 0; timeout and gap counters = 0.
  - An in-flight operation is abandoned with no response.
- FSM states are IDLE, RUN, DRAIN, GAP. All outputs are registered.
- IDLE, when any req bit is set:
  - Select the first set bit at or after rr_ptr, wrapping.
  - Latch its req_vec into sm_vec_in and store its id.
  - Pulse grant[id] for 1 cycle; set busy.
  - Set rr_ptr = (id+1) mod NUM_REQ; go to RUN.
- RUN:
  - sm_enable = 1 for every cycle in RUN.
  - Timeout counter increments each cycle.
  - On sm_data_valid = 1: go to DRAIN, sm_enable = 0 from the next cycle.
  - On counter = TIMEOUT with no valid: drop sm_enable, pulse resp_err with resp_id = id, go to GAP.
- DRAIN (1 cycle):
  - Capture sm_vec_out into resp_vec.
  - Pulse resp_done with resp_id = id in the following cycle; go to GAP.
- GAP:
  - sm_enable stays low for GAP_CYCLES cycles, then go to IDLE and clear busy.
  - req is not arbitrated until IDLE.
- Timing: resp_done is high exactly 2 cycles after the cycle in which sm_data_valid is high.
- Stray sm_data_valid in IDLE, DRAIN or GAP is ignored.
- A requester dropping req mid-operation does not abort it; the response is still issued.
- sm_vec_in changes only on grant, so the engine sees a stable operand while enabled.
- Back-to-back requests from the same requester are allowed; fairness comes from the rr pointer.
- No simultaneous resp_done and resp_err ever.
- Width rules: resp_id width is max(1, $clog2(NUM_REQ)); the timeout counter is $clog2(TIMEOUT+1) bits and saturates.

Test Plan:
- Single request: engine model with valid 4 cycles after enable rises, req[2] with vector {1,2,3,4}.
  - Required: grant = 4'b0100; sm_enable high 4 cycles.
  - Required: resp_done 2 cycles after valid; resp_id = 2; resp_vec = model output.
- All four req held continuously.
  - Required: grant order 0,1,2,3,0.
  - Required: sm_enable low ≥ GAP_CYCLES between operations; each resp_id matches its grant.
- Engine never asserts valid, TIMEOUT = 31.
  - Required: sm_enable drops after 31 RUN cycles; resp_err pulses once with the correct id.
  - Required: the next request is served normally.
- Reset asserted in RUN after 2 enable cycles.
  - Required: next cycle sm_enable = 0, busy = 0, no resp pulse, rr_ptr = 0; req[3] is then granted first.
- req[1] dropped mid-RUN.
  - Required: operation completes; resp_done with resp_id = 1 is still issued.
- Stray sm_data_valid in IDLE and GAP.
  - Required: no resp_done, no state change.
- req[0] and req[2] set simultaneously after a grant to id 0.
  - Required: id 2 is granted next, not id 0.
